// File: rtl/axi_mem_slave_v2.sv
// AXI4 memory-model slave: byte-addressed RAM with independent write and read FSMs.
// Supports FIXED/INCR/WRAP bursts, byte strobes, SLVERR on out-of-range beats, and read wait states.
`timescale 1ns/1ps
module axi_mem_slave_v2 #(
  parameter int AXI_ID_WD   = 2,
  parameter int AXI_DATA_WD = 32,
  parameter int AXI_ADDR_WD = 32,
  parameter int AXI_STRB_WD = 4,
  parameter int MEM_BYTES   = 4096,
  parameter int RD_WAIT     = 0
) (
  input  logic                   S_AXI_ACLK,
  input  logic                   S_AXI_ARESET,
  input  logic [AXI_ADDR_WD-1:0] S_AXI_AWADDR,
  input  logic [AXI_ID_WD-1:0]   S_AXI_AWID,
  input  logic [1:0]             S_AXI_AWBURST,
  input  logic [2:0]             S_AXI_AWSIZE,
  input  logic [7:0]             S_AXI_AWLEN,
  input  logic                   S_AXI_AWVALID,
  output logic                   S_AXI_AWREADY,
  input  logic [AXI_DATA_WD-1:0] S_AXI_WDATA,
  input  logic [AXI_STRB_WD-1:0] S_AXI_WSTRB,
  input  logic                   S_AXI_WLAST,
  input  logic                   S_AXI_WVALID,
  output logic                   S_AXI_WREADY,
  output logic [AXI_ID_WD-1:0]   S_AXI_BID,
  output logic [1:0]             S_AXI_BRESP,
  output logic                   S_AXI_BVALID,
  input  logic                   S_AXI_BREADY,
  input  logic [AXI_ADDR_WD-1:0] S_AXI_ARADDR,
  input  logic [AXI_ID_WD-1:0]   S_AXI_ARID,
  input  logic [1:0]             S_AXI_ARBURST,
  input  logic [2:0]             S_AXI_ARSIZE,
  input  logic [7:0]             S_AXI_ARLEN,
  input  logic                   S_AXI_ARVALID,
  output logic                   S_AXI_ARREADY,
  output logic [AXI_DATA_WD-1:0] S_AXI_RDATA,
  output logic                   S_AXI_RLAST,
  output logic [AXI_ID_WD-1:0]   S_AXI_RID,
  output logic [1:0]             S_AXI_RRESP,
  output logic                   S_AXI_RVALID,
  input  logic                   S_AXI_RREADY
);

  localparam int          AW     = AXI_ADDR_WD;
  localparam int unsigned SW     = AXI_STRB_WD;
  localparam int unsigned SZ_MAX = $clog2(AXI_STRB_WD);
  localparam int          MEM_AW = $clog2(MEM_BYTES);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;

  logic [7:0] mem [MEM_BYTES];

  function automatic logic oob(input logic [AW-1:0] a);
    return |a[AW-1:MEM_AW];
  endfunction

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  function automatic logic [2:0] eff_size(input logic [2:0] s);
    return (32'(s) > SZ_MAX) ? 3'(SZ_MAX) : s;
  endfunction

  // Reserved burst and malformed WRAP lengths run as INCR (flagged via cfg_err).
  function automatic logic [1:0] eff_burst(input logic [1:0] b, input logic [7:0] len);
    return ((b == 2'b11) || ((b == 2'b10) && !wrap_len_ok(len))) ? 2'b01 : b;
  endfunction

  function automatic logic cfg_err(input logic [1:0] b, input logic [2:0] s, input logic [7:0] len);
    return (b == 2'b11) || ((b == 2'b10) && !wrap_len_ok(len)) || (32'(s) > SZ_MAX);
  endfunction

  function automatic logic lane_en(input logic [AW-1:0] a, input logic [2:0] sz, input int unsigned k);
    int unsigned nb, lo;
    nb = 32'd1 << sz;
    lo = 32'(a[SZ_MAX-1:0]) & ~(nb - 32'd1);
    return (k >= lo) && (k < lo + nb);
  endfunction

  function automatic logic [MEM_AW-1:0] mem_idx(input logic [AW-1:0] a, input int unsigned k);
    return {a[MEM_AW-1:SZ_MAX], SZ_MAX'(k)};
  endfunction

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [2:0] sz,
                                              input logic [1:0] b, input logic [7:0] len);
    logic [AW-1:0] inc, bound;
    inc   = AW'(1) << sz;
    bound = (AW'(len) + AW'(1)) << sz;
    case (b)
      2'b00:   return a;
      2'b10:   return (a & ~(bound - AW'(1))) | ((a + inc) & (bound - AW'(1)));
      default: return (a & ~(inc - AW'(1))) + inc;
    endcase
  endfunction

  // ---------------- write channel ----------------
  wstate_t          w_state, w_next;
  logic [AW-1:0]    waddr;
  logic [2:0]       wsize;
  logic [1:0]       wburst;
  logic [7:0]       wlen, wcnt;
  logic             werr;
  logic [AXI_ID_WD-1:0] bid;
  logic [1:0]       bresp;
  logic             aw_fire, w_fire, w_last_beat, w_done, w_err_now;

  assign aw_fire     = (w_state == W_IDLE) && S_AXI_AWVALID;
  assign w_fire      = (w_state == W_DATA) && S_AXI_WVALID;
  assign w_last_beat = (wcnt == wlen);
  assign w_done      = w_last_beat || S_AXI_WLAST;
  assign w_err_now   = werr || oob(waddr) || (S_AXI_WLAST && !w_last_beat);

  // Write FSM next-state.
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (S_AXI_AWVALID) w_next = W_DATA;
      W_DATA:  if (S_AXI_WVALID && w_done) w_next = W_RESP;
      W_RESP:  if (S_AXI_BREADY) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Write state, burst tracking and response registers.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      w_state <= W_IDLE;
      waddr   <= '0;
      wsize   <= '0;
      wburst  <= '0;
      wlen    <= '0;
      wcnt    <= '0;
      werr    <= 1'b0;
      bid     <= '0;
      bresp   <= '0;
    end else begin
      w_state <= w_next;
      if (aw_fire) begin
        waddr  <= S_AXI_AWADDR;
        wsize  <= eff_size(S_AXI_AWSIZE);
        wburst <= eff_burst(S_AXI_AWBURST, S_AXI_AWLEN);
        wlen   <= S_AXI_AWLEN;
        wcnt   <= '0;
        werr   <= cfg_err(S_AXI_AWBURST, S_AXI_AWSIZE, S_AXI_AWLEN);
        bid    <= S_AXI_AWID;
      end
      if (w_fire) begin
        waddr <= next_addr(waddr, wsize, wburst, wlen);
        wcnt  <= wcnt + 8'd1;
        werr  <= w_err_now;
        if (w_done) bresp <= w_err_now ? 2'b10 : 2'b00;
      end
    end
  end

  // RAM byte writes (no reset on contents; suppressed while reset is asserted).
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESET && w_fire && !oob(waddr)) begin
      for (int unsigned k = 0; k < SW; k++) begin
        if (S_AXI_WSTRB[k] && lane_en(waddr, wsize, k))
          mem[mem_idx(waddr, k)] <= S_AXI_WDATA[8*k +: 8];
      end
    end
  end

  assign S_AXI_AWREADY = (w_state == W_IDLE);
  assign S_AXI_WREADY  = (w_state == W_DATA);
  assign S_AXI_BVALID  = (w_state == W_RESP);
  assign S_AXI_BID     = bid;
  assign S_AXI_BRESP   = bresp;

  // ---------------- read channel ----------------
  rstate_t          r_state, r_next;
  logic [AW-1:0]    raddr, ld_addr;
  logic [2:0]       rsize, ld_size;
  logic [1:0]       rburst, ld_burst;
  logic [7:0]       rlen, rcnt, ld_len, ld_cnt;
  logic             rerr, ld_err, r_load, ar_fire;
  logic [3:0]       wait_cnt;
  logic [AXI_ID_WD-1:0]   rid;
  logic [1:0]             rresp;
  logic                   rlast;
  logic [AXI_DATA_WD-1:0] rdata;

  assign ar_fire = (r_state == R_IDLE) && S_AXI_ARVALID;

  // Read FSM next-state plus beat-load source. With no wait states the first beat
  // is loaded straight from the AR inputs, so the load operands are muxed on R_IDLE.
  always_comb begin
    r_next   = r_state;
    r_load   = 1'b0;
    ld_addr  = raddr;
    ld_size  = rsize;
    ld_burst = rburst;
    ld_len   = rlen;
    ld_err   = rerr;
    ld_cnt   = rcnt;
    if (r_state == R_IDLE) begin
      ld_addr  = S_AXI_ARADDR;
      ld_size  = eff_size(S_AXI_ARSIZE);
      ld_burst = eff_burst(S_AXI_ARBURST, S_AXI_ARLEN);
      ld_len   = S_AXI_ARLEN;
      ld_err   = cfg_err(S_AXI_ARBURST, S_AXI_ARSIZE, S_AXI_ARLEN);
      ld_cnt   = '0;
    end
    case (r_state)
      R_IDLE: if (S_AXI_ARVALID) begin
        r_next = (RD_WAIT == 0) ? R_DATA : R_WAIT;
        r_load = (RD_WAIT == 0);
      end
      R_WAIT: if (wait_cnt == 4'd0) begin
        r_next = R_DATA;
        r_load = 1'b1;
      end
      R_DATA: if (S_AXI_RREADY) begin
        if (rlast)              r_next = R_IDLE;
        else if (RD_WAIT == 0)  r_load = 1'b1;
        else                    r_next = R_WAIT;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Read state, wait counter, burst tracking and registered R outputs.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_state  <= R_IDLE;
      raddr    <= '0;
      rsize    <= '0;
      rburst   <= '0;
      rlen     <= '0;
      rcnt     <= '0;
      rerr     <= 1'b0;
      wait_cnt <= '0;
      rid      <= '0;
      rresp    <= '0;
      rlast    <= 1'b0;
      rdata    <= '0;
    end else begin
      r_state <= r_next;
      if (ar_fire) begin
        rid    <= S_AXI_ARID;
        raddr  <= S_AXI_ARADDR;
        rsize  <= ld_size;
        rburst <= ld_burst;
        rlen   <= ld_len;
        rerr   <= ld_err;
        rcnt   <= '0;
      end
      if ((r_next == R_WAIT) && (r_state != R_WAIT))
        wait_cnt <= 4'(RD_WAIT - 1);
      else if ((r_state == R_WAIT) && (wait_cnt != 4'd0))
        wait_cnt <= wait_cnt - 4'd1;
      if (r_load) begin
        raddr <= next_addr(ld_addr, ld_size, ld_burst, ld_len);
        rcnt  <= ld_cnt + 8'd1;
        rlast <= (ld_cnt == ld_len);
        rresp <= (ld_err || oob(ld_addr)) ? 2'b10 : 2'b00;
        for (int unsigned k = 0; k < SW; k++)
          rdata[8*k +: 8] <= (lane_en(ld_addr, ld_size, k) && !oob(ld_addr)) ?
                             mem[mem_idx(ld_addr, k)] : 8'h00;
      end
    end
  end

  assign S_AXI_ARREADY = (r_state == R_IDLE);
  assign S_AXI_RVALID  = (r_state == R_DATA);
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_RLAST   = rlast;
  assign S_AXI_RID     = rid;
  assign S_AXI_RRESP   = rresp;

endmodule
